// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the asynchronous SRAM responder.
// Bus geometry, byte-lane indices and the read-side FSM encoding.
package mips_mem_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int LANE_W  = 8;
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRIVE
  } rd_state_t;

  function automatic logic [LANE_W-1:0] lane_of(
    input logic [SRAM_DW-1:0] word,
    input int                 lane
  );
    lane_of = word[lane*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Word storage with independent byte-lane write enables.
// Synchronous write, combinational read; contents survive reset.
module sram_byte_array
  import mips_mem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic               clock,
  input  logic [1:0]         lane_we,
  input  logic [AW-1:0]      waddr,
  input  logic [SRAM_DW-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [SRAM_DW-1:0] rdata
);

  logic [SRAM_DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (lane_we[LANE_HI])
      mem[waddr][LANE_HI*LANE_W +: LANE_W] <= lane_of(wdata, LANE_HI);
    if (lane_we[LANE_LO])
      mem[waddr][LANE_LO*LANE_W +: LANE_W] <= lane_of(wdata, LANE_LO);
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// Synchronous responder for an async-style SRAM bus with read latency,
// transaction counters and a sticky bus-turnaround violation flag.
module sram_responder
  import mips_mem_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int MEM_AW   = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SRAM_AW-1:0] addr,
  inout  wire  [SRAM_DW-1:0] data,
  input  logic               wre,
  input  logic               oute,
  input  logic               hb_mask,
  input  logic               lb_mask,
  input  logic               chip_en,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count,
  output logic               err
);

  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  rd_state_t          state, state_n;
  logic [2:0]         cnt, cnt_n;
  logic               sel, wr_req, rd_req;
  logic               any_lane, changed;
  logic               latch, enter, restart;
  logic [1:0]         lane_we;
  logic [SRAM_DW-1:0] rdata, rd_q;
  logic [SRAM_AW-1:0] addr_q;
  logic               hbm_q, lbm_q;
  logic               drv_hb_q, drv_lb_q;
  logic               bus_en, drove_q;

  assign sel      = ~chip_en;
  assign wr_req   = sel & ~wre;
  assign rd_req   = sel & wre & ~oute;
  assign any_lane = ~(hb_mask & lb_mask);
  assign lane_we  = {~hb_mask, ~lb_mask} & {2{wr_req}};
  assign changed  = {addr, hb_mask, lb_mask} != {addr_q, hbm_q, lbm_q};

  sram_byte_array #(
    .AW(MEM_AW)
  ) u_array (
    .clock  (clock),
    .lane_we(lane_we),
    .waddr  (addr[MEM_AW-1:0]),
    .wdata  (data),
    .raddr  (addr[MEM_AW-1:0]),
    .rdata  (rdata)
  );

  // Drive strictly gated by the live request so a dropped OE releases at once.
  assign bus_en = (state == S_DRIVE) & rd_req;

  assign data[LANE_HI*LANE_W +: LANE_W] = (bus_en & ~drv_hb_q) ?
    lane_of(rd_q, LANE_HI) : {LANE_W{1'bz}};
  assign data[LANE_LO*LANE_W +: LANE_W] = (bus_en & ~drv_lb_q) ?
    lane_of(rd_q, LANE_LO) : {LANE_W{1'bz}};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    enter   = 1'b0;
    restart = 1'b0;
    unique case (state)
      S_IDLE: restart = rd_req;
      S_WAIT: begin
        if (!rd_req) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (changed) begin
          restart = 1'b1;
        end else if (cnt <= 3'd1) begin
          state_n = S_DRIVE;
          cnt_n   = '0;
          enter   = 1'b1;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      S_DRIVE: begin
        if (!rd_req) state_n = S_IDLE;
        else if (changed) restart = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (restart) begin
      latch = 1'b1;
      if (READ_LAT == 1) begin
        state_n = S_DRIVE;
        cnt_n   = '0;
        enter   = 1'b1;
      end else begin
        state_n = S_WAIT;
        cnt_n   = LAT_LOAD;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      hbm_q    <= 1'b1;
      lbm_q    <= 1'b1;
      rd_q     <= '0;
      drv_hb_q <= 1'b1;
      drv_lb_q <= 1'b1;
      rd_count <= '0;
      wr_count <= '0;
      err      <= 1'b0;
      drove_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      drove_q <= bus_en;
      if (latch) begin
        addr_q <= addr;
        hbm_q  <= hb_mask;
        lbm_q  <= lb_mask;
      end
      if (enter) begin
        rd_q     <= rdata;
        drv_hb_q <= hb_mask;
        drv_lb_q <= lb_mask;
        rd_count <= rd_count + 16'd1;
      end
      if (wr_req && any_lane) wr_count <= wr_count + 16'd1;
      // Writing right after we drove means the initiator did not turn the bus.
      if (wr_req && drove_q) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: vector table, corner sequences, random traffic.
// Undriven bus lanes are pulled up, so a released lane reads as 8'hFF.
module tb_sram_responder;

  localparam int READ_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] addr;
  wire  [15:0] data;
  logic        wre, oute, hb_mask, lb_mask, chip_en;
  logic [15:0] rd_count, wr_count;
  logic        err;
  logic [15:0] tb_dat;
  logic        tb_drv;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [15:0] mdl [4096];
  logic [15:0] m_rd, m_wr;

  assign data = tb_drv ? tb_dat : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (data[g]);
  end

  sram_responder #(
    .READ_LAT(READ_LAT),
    .MEM_AW  (12)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .data    (data),
    .wre     (wre),
    .oute    (oute),
    .hb_mask (hb_mask),
    .lb_mask (lb_mask),
    .chip_en (chip_en),
    .rd_count(rd_count),
    .wr_count(wr_count),
    .err     (err)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    bit          is_rd;
    logic [17:0] a;
    logic [15:0] d;
    logic        hb;
    logic        lb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic logic [15:0] bus_view(input logic [15:0] w,
                                           input logic hb, input logic lb);
    bus_view = {hb ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]};
  endfunction

  task automatic go_idle();
    chip_en = 1'b1; wre = 1'b1; oute = 1'b1;
    hb_mask = 1'b1; lb_mask = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic model_write(input logic [17:0] a, input logic [15:0] d,
                             input logic hb, input logic lb);
    if (!hb) mdl[a[11:0]][15:8] = d[15:8];
    if (!lb) mdl[a[11:0]][7:0]  = d[7:0];
    if (!(hb && lb)) m_wr = m_wr + 16'd1;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d,
                    input logic hb, input logic lb);
    @(negedge clock);
    addr = a; tb_dat = d; tb_drv = 1'b1;
    chip_en = 1'b0; wre = 1'b0; oute = 1'b1;
    hb_mask = hb; lb_mask = lb;
    @(posedge clock); #1;
    model_write(a, d, hb, lb);
    go_idle();
  endtask

  task automatic rd(input string name, input logic [17:0] a,
                    input logic hb, input logic lb, input logic [15:0] exp);
    @(negedge clock);
    addr = a; tb_drv = 1'b0;
    chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
    hb_mask = hb; lb_mask = lb;
    for (int i = 1; i <= READ_LAT; i++) begin
      @(posedge clock); #1;
      if (i < READ_LAT) check({name, " early"}, data, 16'hFFFF);
    end
    check(name, data, exp);
    m_rd = m_rd + 16'd1;
    go_idle();
    @(posedge clock); #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " rd_count"}, rd_count, m_rd);
    check({tag, " wr_count"}, wr_count, m_wr);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    go_idle();
    #2;
    m_rd = '0; m_wr = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [17:0] ra;
    logic [15:0] rdat;
    logic        rhb, rlb;

    vecs[0]  = '{1'b0, 18'h00005, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b0, 18'h00007, 16'h1234, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 18'h00007, 16'hAB00, 1'b0, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 18'h00007, 16'h0000, 1'b0, 1'b0, 16'hAB34};
    vecs[5]  = '{1'b1, 18'h00007, 16'h0000, 1'b1, 1'b0, 16'hFF34};
    vecs[6]  = '{1'b0, 18'h01003, 16'h00FF, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 18'h00003, 16'h0000, 1'b0, 1'b0, 16'h00FF};
    vecs[8]  = '{1'b0, 18'h00009, 16'h1111, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 18'h00009, 16'h2222, 1'b1, 1'b1, 16'h0000};
    vecs[10] = '{1'b1, 18'h00009, 16'h0000, 1'b0, 1'b0, 16'h1111};
    vecs[11] = '{1'b1, 18'h3F009, 16'h0000, 1'b0, 1'b1, 16'h11FF};

    m_rd = '0; m_wr = '0;
    addr = '0; tb_dat = '0;
    go_idle();
    reset = 1'b1;
    #1;
    check("reset bus", data, 16'hFFFF);
    check("reset err", {15'd0, err}, 16'h0000);
    check_counts("reset");
    #20;
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].is_rd)
        rd($sformatf("vec%0d", i), vecs[i].a, vecs[i].hb, vecs[i].lb,
           vecs[i].exp);
      else
        wr(vecs[i].a, vecs[i].d, vecs[i].hb, vecs[i].lb);
      check_counts($sformatf("vec%0d", i));
    end
    check("no err after table", {15'd0, err}, 16'h0000);

    // Abandon in WAIT: no count, bus released
    @(negedge clock);
    addr = 18'h5; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
    hb_mask = 1'b0; lb_mask = 1'b0;
    @(posedge clock); #1;
    oute = 1'b1; #1;
    check("abandon wait bus", data, 16'hFFFF);
    @(posedge clock); #1;
    go_idle();
    check_counts("abandon wait");
    rd("after abandon", 18'h5, 1'b0, 1'b0, 16'hBEEF);

    // Drop OE in DRIVE: bus released in the same cycle
    @(negedge clock);
    addr = 18'h5; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
    hb_mask = 1'b0; lb_mask = 1'b0;
    repeat (READ_LAT) @(posedge clock);
    #1;
    check("drive bus", data, 16'hBEEF);
    oute = 1'b1; #1;
    check("drop drive bus", data, 16'hFFFF);
    m_rd = m_rd + 16'd1;
    @(posedge clock); #1;
    go_idle();
    check_counts("drop drive");

    // Address change in WAIT restarts with full latency
    @(negedge clock);
    addr = 18'h5; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
    hb_mask = 1'b0; lb_mask = 1'b0;
    @(posedge clock);
    @(negedge clock);
    addr = 18'h7;
    for (int i = 1; i <= READ_LAT; i++) begin
      @(posedge clock); #1;
      if (i < READ_LAT) check("restart early", data, 16'hFFFF);
    end
    check("restart data", data, 16'hAB34);
    m_rd = m_rd + 16'd1;
    go_idle();
    @(posedge clock); #1;
    check_counts("restart");

    // Reset while driving
    @(negedge clock);
    addr = 18'h7; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
    hb_mask = 1'b0; lb_mask = 1'b0;
    repeat (READ_LAT) @(posedge clock);
    #1;
    check("pre-reset drive", data, 16'hAB34);
    reset = 1'b1; #1;
    check("reset mid-read bus", data, 16'hFFFF);
    check("reset mid-read rd", rd_count, 16'h0000);
    check("reset mid-read wr", wr_count, 16'h0000);
    m_rd = '0; m_wr = '0;
    go_idle();
    @(negedge clock);
    reset = 1'b0;
    rd("post reset read", 18'h7, 1'b0, 1'b0, 16'hAB34);

    // Write right after a driven cycle sets the sticky error
    check("err clear", {15'd0, err}, 16'h0000);
    @(negedge clock);
    addr = 18'h5; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
    hb_mask = 1'b0; lb_mask = 1'b0;
    repeat (READ_LAT) @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    addr = 18'h9; tb_dat = 16'h3333; tb_drv = 1'b1; wre = 1'b0; oute = 1'b1;
    @(posedge clock); #1;
    check("err set", {15'd0, err}, 16'h0001);
    model_write(18'h9, 16'h3333, 1'b0, 1'b0);
    m_rd = m_rd + 16'd1;
    go_idle();
    wr(18'h11, 16'h7777, 1'b0, 1'b0);
    rd("err traffic", 18'h9, 1'b0, 1'b0, 16'h3333);
    check("err sticky", {15'd0, err}, 16'h0001);
    check_counts("err");
    pulse_reset();
    check("err reset", {15'd0, err}, 16'h0000);

    // 65536 back-to-back writes wrap the write counter
    @(negedge clock);
    addr = 18'h20; tb_dat = 16'h4444; tb_drv = 1'b1;
    chip_en = 1'b0; wre = 1'b0; oute = 1'b1;
    hb_mask = 1'b0; lb_mask = 1'b0;
    repeat (65536) @(posedge clock);
    #1;
    go_idle();
    mdl[12'h020] = 16'h4444;
    check("wr_count wrap", wr_count, 16'h0000);
    wr(18'h20, 16'h5555, 1'b1, 1'b1);
    check("no-lane write count", wr_count, 16'h0000);
    rd("no-lane write data", 18'h20, 1'b0, 1'b0, 16'h4444);

    // Random traffic against the array model
    for (int i = 0; i < 16; i++)
      wr(18'h100 | 18'(i), 16'($urandom), 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      ra   = {6'($urandom_range(0, 63)), 8'h01, 4'($urandom_range(0, 15))};
      rdat = 16'($urandom);
      rhb  = 1'($urandom_range(0, 1));
      rlb  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) wr(ra, rdat, rhb, rlb);
      else rd($sformatf("rand%0d", n), ra, rhb, rlb,
              bus_view(mdl[ra[11:0]], rhb, rlb));
    end
    check_counts("random");
    check("random err", {15'd0, err}, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
